// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: datapath width, PC increment, NOP encoding, reset PC.
// Purely declarative; no latency or backpressure of its own.
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/top_fetch_module_instr_memory.sv
// Byte-addressed instruction store with aligned little-endian word read; latency 0 (combinational).
// No backpressure; returns NOP when reads are disabled or the word lies beyond the array.
module instr_memory
  import fetch_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [XLEN-1:0] addr,
  input  logic            rd_en,
  output logic [XLEN-1:0] rdata
);

  localparam int AW = $clog2(IMEM_BYTES);

  // Contents are loaded from outside (benches write this array hierarchically).
  logic [7:0] instr_mem [0:IMEM_BYTES-1];

  logic [AW-1:0] base;
  logic          in_range;

  assign base     = addr[AW-1:0];
  assign in_range = addr < XLEN'(IMEM_BYTES);

  always_comb begin
    rdata = NOP_INSTR;
    if (rd_en && in_range) begin
      rdata = {instr_mem[base + AW'(3)], instr_mem[base + AW'(2)],
               instr_mem[base + AW'(1)], instr_mem[base]};
    end
  end

endmodule

// File: rtl/top_fetch_module.sv
// RV32 fetch stage: PC register, +4 adder, redirect mux; instruction read in the same cycle (latency 0).
// No backpressure in the base build; FETCH_STALL_EN adds stall_fetch to hold the PC (redirect overrides it).
module top_fetch_module
  import fetch_pkg::*;
#(
  parameter int              IMEM_BYTES = 1024,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_select_execute,
  input  logic            rd_wr,
  input  logic [XLEN-1:0] pc_target_execute,
`ifdef FETCH_STALL_EN
  input  logic            stall_fetch,
`endif
  output logic [XLEN-1:0] instruction_fetch,
  output logic [XLEN-1:0] pc_fetch,
  output logic [XLEN-1:0] next_pc_fetch
);

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] fetch_addr;

  assign next_pc_fetch = pc_fetch + PC_INC;
  assign fetch_addr    = {pc_fetch[XLEN-1:2], 2'b00};

  always_comb begin
    pc_next = next_pc_fetch;
    if (pc_select_execute) begin
      pc_next = pc_target_execute;
`ifdef FETCH_STALL_EN
    end else if (stall_fetch) begin
      pc_next = pc_fetch;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_fetch <= RESET_PC;
    end else begin
      pc_fetch <= pc_next;
    end
  end

  instr_memory #(
    .IMEM_BYTES(IMEM_BYTES)
  ) memory_inst (
    .addr (fetch_addr),
    .rd_en(rd_wr),
    .rdata(instruction_fetch)
  );

endmodule

// File: tb/tb_top_fetch_module.sv
// Directed vector bench for top_fetch_module: table of per-edge stimulus/expectations plus reset and stall sequences.
module tb_top_fetch_module;

  logic        clk;
  logic        rst;
  logic        pc_select_execute;
  logic        rd_wr;
  logic [31:0] pc_target_execute;
  logic [31:0] instruction_fetch;
  logic [31:0] pc_fetch;
  logic [31:0] next_pc_fetch;
`ifdef FETCH_STALL_EN
  logic        stall_fetch;
`endif

  int passed;
  int total;

  top_fetch_module #(
    .IMEM_BYTES(1024),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_select_execute(pc_select_execute),
    .rd_wr            (rd_wr),
    .pc_target_execute(pc_target_execute),
`ifdef FETCH_STALL_EN
    .stall_fetch      (stall_fetch),
`endif
    .instruction_fetch(instruction_fetch),
    .pc_fetch         (pc_fetch),
    .next_pc_fetch    (next_pc_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        rd;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    dut.memory_inst.instr_mem[addr]     = w[7:0];
    dut.memory_inst.instr_mem[addr + 1] = w[15:8];
    dut.memory_inst.instr_mem[addr + 2] = w[23:16];
    dut.memory_inst.instr_mem[addr + 3] = w[31:24];
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b0;
    rd_wr = 1'b1;
    pc_select_execute = 1'b0;
    pc_target_execute = 32'h0;
`ifdef FETCH_STALL_EN
    stall_fetch = 1'b0;
`endif

    // bytes 0..3 = DE AD BE EF, 4..7 = BA AD C0 DE
    load_word(0,    32'hEFBEADDE);
    load_word(4,    32'hDEC0ADBA);
    load_word(8,    32'h44332211);
    load_word(12,   32'h88776655);
    load_word(1020, 32'h04030201);

    //          sel   rd    target         pc             next           instr
    vecs[0]  = '{1'b0, 1'b1, 32'h0,        32'h4,        32'h8,        32'hDEC0ADBA};
    vecs[1]  = '{1'b0, 1'b1, 32'h0,        32'h8,        32'hC,        32'h44332211};
    vecs[2]  = '{1'b0, 1'b1, 32'h0,        32'hC,        32'h10,       32'h88776655};
    vecs[3]  = '{1'b1, 1'b1, 32'h4,        32'h4,        32'h8,        32'hDEC0ADBA};
    vecs[4]  = '{1'b1, 1'b1, 32'h4,        32'h4,        32'h8,        32'hDEC0ADBA};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,        32'h8,        32'hC,        32'h44332211};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'h10,       32'h00000013};
    vecs[7]  = '{1'b1, 1'b1, 32'h1000,     32'h1000,     32'h1004,     32'h00000013};
    vecs[8]  = '{1'b1, 1'b1, 32'h3FC,      32'h3FC,      32'h400,      32'h04030201};
    vecs[9]  = '{1'b0, 1'b1, 32'h0,        32'h400,      32'h404,      32'h00000013};
    vecs[10] = '{1'b1, 1'b1, 32'h6,        32'h6,        32'hA,        32'hDEC0ADBA};
    vecs[11] = '{1'b0, 1'b1, 32'h0,        32'hA,        32'hE,        32'h44332211};
    vecs[12] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h00000013};
    vecs[13] = '{1'b0, 1'b1, 32'h0,        32'h0,        32'h4,        32'hEFBEADDE};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h4,        32'h00000013};

    // Reset values while rst is held low from time zero
    #1;
    check("reset pc",    pc_fetch,          32'h0);
    check("reset next",  next_pc_fetch,     32'h4);
    check("reset instr", instruction_fetch, 32'hEFBEADDE);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      pc_select_execute = vecs[i].sel;
      rd_wr             = vecs[i].rd;
      pc_target_execute = vecs[i].tgt;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pc", i),    pc_fetch,          vecs[i].pc);
      check($sformatf("vec%0d next", i),  next_pc_fetch,     vecs[i].nxt);
      check($sformatf("vec%0d instr", i), instruction_fetch, vecs[i].ins);
      @(negedge clk);
    end

    // Mid-run asynchronous reset, held 10 ns across a rising edge
    pc_select_execute = 1'b0;
    rd_wr = 1'b1;
    @(posedge clk);
    #1;
    check("pre-reset pc", pc_fetch, 32'h4);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset pc",    pc_fetch,          32'h0);
    check("async reset next",  next_pc_fetch,     32'h4);
    check("async reset instr", instruction_fetch, 32'hEFBEADDE);
    #9;
    rst = 1'b1;
    check("reset held pc", pc_fetch, 32'h0);
    pc_select_execute = 1'b1;
    pc_target_execute = 32'h8;
    @(posedge clk);
    #1;
    check("post-reset redirect pc", pc_fetch, 32'h8);

`ifdef FETCH_STALL_EN
    @(negedge clk);
    pc_select_execute = 1'b0;
    stall_fetch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d pc", k), pc_fetch, 32'h8);
    end
    @(negedge clk);
    pc_select_execute = 1'b1;
    pc_target_execute = 32'h0;
    @(posedge clk);
    #1;
    check("stall redirect pc", pc_fetch, 32'h0);
    @(negedge clk);
    pc_select_execute = 1'b0;
    stall_fetch = 1'b0;
    @(posedge clk);
    #1;
    check("unstall pc", pc_fetch, 32'h4);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
